// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: SPI mode-0 slave datapath.
// Deserialises MOSI into WIDTH-bit words and serialises a parallel word onto
// MISO, driven by pre-conditioned SCLK edge pulses and CS level.
// Optional build macro SPI_FRAME_SHIFTER_LSB_FIRST_EN selects LSB-first
// shifting in both directions; default (undefined) is MSB-first.
module spi_frame_shifter #(
    parameter int WIDTH      = 8,
    parameter int COUNTWIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk_posedge,
    input  logic             sclk_negedge,
    input  logic             cs_n,
    input  logic             mosi,
    input  logic [WIDTH-1:0] tx_data,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_taken,
    output logic             frame_error,
    output logic             busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [COUNTWIDTH-1:0] r_count;
    logic [WIDTH-1:0]      r_rx_shift;
    logic [WIDTH-1:0]      r_tx_shift;
    logic [WIDTH-1:0]      r_rx_data;
    logic                  r_miso;
    logic                  r_miso_oe;
    logic                  r_rx_valid;
    logic                  r_tx_taken;
    logic                  r_frame_error;
    logic                  r_reload;      // next negedge presents head of reloaded word

    logic                  w_start;
    logic                  w_abort;
    logic                  w_pos;
    logic                  w_neg;
    logic                  w_last;
    logic [WIDTH-1:0]      w_rx_next;
    logic [WIDTH-1:0]      w_tx_shifted;
    logic                  w_tx_head;
    logic                  w_shift_head;
    logic                  w_load_head;

    // CS release outranks edge pulses; a posedge outranks a same-cycle negedge.
    assign w_start = (r_state == IDLE)  && !cs_n;
    assign w_abort = (r_state == SHIFT) &&  cs_n;
    assign w_pos   = (r_state == SHIFT) && !cs_n && sclk_posedge;
    assign w_neg   = (r_state == SHIFT) && !cs_n && sclk_negedge && !sclk_posedge;
    assign w_last  = (r_count == COUNTWIDTH'(WIDTH - 1));

`ifdef SPI_FRAME_SHIFTER_LSB_FIRST_EN
    assign w_rx_next    = {mosi, r_rx_shift[WIDTH-1:1]};
    assign w_tx_shifted = {1'b0, r_tx_shift[WIDTH-1:1]};
    assign w_tx_head    = r_tx_shift[0];
    assign w_shift_head = w_tx_shifted[0];
    assign w_load_head  = tx_data[0];
`else
    assign w_rx_next    = {r_rx_shift[WIDTH-2:0], mosi};
    assign w_tx_shifted = {r_tx_shift[WIDTH-2:0], 1'b0};
    assign w_tx_head    = r_tx_shift[WIDTH-1];
    assign w_shift_head = w_tx_shifted[WIDTH-1];
    assign w_load_head  = tx_data[WIDTH-1];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: enter on CS low, leave on CS high
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!cs_n) w_state_nxt = SHIFT;
            SHIFT:   if (cs_n)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift datapath, bit counter and registered handshake pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_rx_data     <= '0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_tx_taken    <= 1'b0;
            r_frame_error <= 1'b0;
            r_reload      <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_taken    <= 1'b0;
            r_frame_error <= 1'b0;
            if (w_start) begin
                // First bit goes out immediately so the master can sample it
                // on the first SCLK rising edge.
                r_tx_shift <= tx_data;
                r_miso     <= w_load_head;
                r_miso_oe  <= 1'b1;
                r_tx_taken <= 1'b1;
                r_count    <= '0;
                r_rx_shift <= '0;
                r_reload   <= 1'b0;
            end else if (w_abort) begin
                r_frame_error <= (r_count != '0);
                r_miso        <= 1'b0;
                r_miso_oe     <= 1'b0;
                r_count       <= '0;
                r_rx_shift    <= '0;
                r_reload      <= 1'b0;
            end else if (w_pos) begin
                r_rx_shift <= w_rx_next;
                if (w_last) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                    r_count    <= '0;
                    r_tx_shift <= tx_data;
                    r_tx_taken <= 1'b1;
                    r_reload   <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_neg) begin
                if (r_reload) begin
                    // Word boundary: present the fresh word's head unshifted.
                    r_miso   <= w_tx_head;
                    r_reload <= 1'b0;
                end else begin
                    r_tx_shift <= w_tx_shifted;
                    r_miso     <= w_shift_head;
                end
            end
        end
    end

    assign miso        = r_miso;
    assign miso_oe     = r_miso_oe;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_taken    = r_tx_taken;
    assign frame_error = r_frame_error;
    assign busy        = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_frame_shifter.sv
// Directed bench for spi_frame_shifter: table of back-to-back words plus
// hand-written abort, CS-toggle and mid-frame reset sequences.
module tb_spi_frame_shifter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sclk_posedge = 1'b0;
    logic         sclk_negedge = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         miso, miso_oe, rx_valid, tx_taken, frame_error, busy;
    logic [W-1:0] rx_data;

    int checks = 0;
    int errors = 0;
    int n_rxv = 0, n_txt = 0, n_fe = 0;

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] mosi_w;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_miso;
    } vec_t;
    vec_t tbl[4];

    spi_frame_shifter #(.WIDTH(W), .COUNTWIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
        .cs_n(cs_n), .mosi(mosi), .tx_data(tx_data),
        .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data),
        .rx_valid(rx_valid), .tx_taken(tx_taken),
        .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse counters: a pulse held two cycles counts twice.
    always @(posedge clk) begin
        if (rx_valid)    n_rxv++;
        if (tx_taken)    n_txt++;
        if (frame_error) n_fe++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bit_idx(input int j);
`ifdef SPI_FRAME_SHIFTER_LSB_FIRST_EN
        return j;
`else
        return W - 1 - j;
`endif
    endfunction

    // One SCLK period: rising pulse (MISO sampled), gap, falling pulse, gap.
    task automatic bit_cycle(input logic b, output logic m);
        @(negedge clk); mosi = b; sclk_posedge = 1'b1; m = miso;
        @(negedge clk); sclk_posedge = 1'b0;
        @(negedge clk); sclk_negedge = 1'b1;
        @(negedge clk); sclk_negedge = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] mw, input logic set_next,
                             input logic [W-1:0] next_tx, output logic [W-1:0] mo);
        logic m;
        mo = '0;
        for (int j = 0; j < W; j++) begin
            bit_cycle(mw[bit_idx(j)], m);
            mo[bit_idx(j)] = m;
            if (j == 0 && set_next) tx_data = next_tx;
        end
    endtask

    task automatic send_bits(input int n);
        logic m;
        for (int j = 0; j < n; j++) bit_cycle(j[0], m);
    endtask

    initial begin
        logic [W-1:0] mo;
        int rxv0, txt0, fe0;

        tbl[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
        tbl[1] = '{8'h81, 8'hFF, 8'hFF, 8'h81};
        tbl[2] = '{8'h7E, 8'h00, 8'h00, 8'h7E};
        tbl[3] = '{8'hC3, 8'h96, 8'h96, 8'hC3};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {miso, miso_oe, rx_data, rx_valid, tx_taken, frame_error, busy}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back frame from the table
        tx_data = tbl[0].tx;
        cs_n = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_miso_oe", miso_oe, 1);
        chk("start_tx_taken", tx_taken, 1);
        for (int i = 0; i < 4; i++) begin
            send_word(tbl[i].mosi_w, (i < 3), (i < 3) ? tbl[(i < 3) ? i + 1 : i].tx : '0, mo);
            chk($sformatf("word%0d_rx_data", i), rx_data, tbl[i].exp_rx);
            chk($sformatf("word%0d_miso", i), mo, tbl[i].exp_miso);
            chk($sformatf("word%0d_rx_valid_cnt", i), n_rxv, i + 1);
            chk($sformatf("word%0d_tx_taken_cnt", i), n_txt, i + 2);
        end
        @(negedge clk); cs_n = 1'b1;
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_miso_oe", miso_oe, 0);
        chk("end_miso", miso, 0);
        @(negedge clk);
        chk("end_no_frame_error", n_fe, 0);

        // Abort after 5 bits
        rxv0 = n_rxv;
        tx_data = 8'hFF;
        cs_n = 1'b0;
        send_bits(5);
        @(negedge clk); cs_n = 1'b1;
        @(negedge clk);
        chk("abort_fe_pulse", frame_error, 1);
        chk("abort_busy", busy, 0);
        chk("abort_miso_oe", miso_oe, 0);
        chk("abort_miso", miso, 0);
        chk("abort_rx_data_kept", rx_data, 8'h96);
        @(negedge clk);
        chk("abort_fe_one_cycle", frame_error, 0);
        @(negedge clk);
        chk("abort_fe_cnt", n_fe, 1);
        chk("abort_no_rx_valid", n_rxv, rxv0);

        // CS toggle without SCLK
        rxv0 = n_rxv; txt0 = n_txt; fe0 = n_fe;
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("toggle_tx_taken", n_txt, txt0 + 1);
        chk("toggle_no_fe", n_fe, fe0);
        chk("toggle_no_rxv", n_rxv, rxv0);

        // Reset mid-frame after 3 bits
        tx_data = 8'h33;
        cs_n = 1'b0;
        send_bits(3);
        @(negedge clk);
        rst_n = 1'b0;
        cs_n = 1'b1;
        #1;
        chk("midreset_outputs", {miso, miso_oe, rx_data, rx_valid, tx_taken, frame_error, busy}, '0);
        fe0 = n_fe;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_no_fe", n_fe, fe0);
        rxv0 = n_rxv;
        tx_data = 8'h5A;
        cs_n = 1'b0;
        send_word(8'hE7, 1'b0, '0, mo);
        chk("postreset_rx_data", rx_data, 8'hE7);
        chk("postreset_miso", mo, 8'h5A);
        @(negedge clk);
        chk("postreset_rxv", n_rxv, rxv0 + 1);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("postreset_no_fe", n_fe, fe0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
